// File: rtl/uart_pkg.sv
// Shared types and frame constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x byte FIFO with registered occupancy flags; no knowledge of UART timing.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [DATA_BITS-1:0]   wdata_i,
    input  logic                   pop_i,
    output logic [DATA_BITS-1:0]   rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, empty_q;
    logic                 do_push, do_pop;

    // A pop frees the slot in the same cycle, so push+pop is accepted when full.
    assign do_push = push_i && (!full_q || pop_i);
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            full_q  <= (level_d == LW'(DEPTH));
            empty_q <= (level_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo_core.sv
// Pin-strobed byte intake, 4-deep buffering and 8N1 serialisation onto a registered tx pin.
module uart_tx_fifo_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH        = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ena_i,
    input  logic [DATA_BITS-1:0]   wr_data_i,
    input  logic                   wr_req_i,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o
);

    localparam int                 CW        = $clog2(CLKS_PER_BIT);
    localparam int                 BW        = $clog2(FRAME_BITS);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]      LAST_DATA = BW'(DATA_BITS);

    logic [2:0]           sync_q;
    logic                 push, pop, cnt_end;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;
    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q, overflow_d;

    // Two flops resolve metastability; the third holds the previous level for rise detect.
    assign push    = sync_q[1] & ~sync_q[2] & ena_i;
    assign cnt_end = (cnt_q == CNT_LAST);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .wdata_i (wr_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    // bit_q tracks frame position: 0 = start, 1..DATA_BITS = data, then stop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && ena_i) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START, DATA: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + BW'(1);
                    if (state_q == START) begin
                        state_d = DATA;
                    end else if (bit_q == LAST_DATA) begin
                        state_d = STOP;
                    end else begin
                        shreg_d = shreg_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_end) begin
                    cnt_d = '0;
                    if (!fifo_empty && ena_i) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        bit_d   = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is derived from next state so the pin itself is a flop.
    always_comb begin
        tx_d = 1'b1;
        if (state_d == START)     tx_d = 1'b0;
        else if (state_d == DATA) tx_d = shreg_d[0];
    end

    assign overflow_d = overflow_q | (push & fifo_full & ~pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], wr_req_i};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != IDLE);
    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Directed bench for uart_tx_fifo_core with CLKS_PER_BIT=4, DEPTH=4.
module tb_uart_tx_fifo_core;

    localparam int CPB = 4;
    localparam int DEP = 4;

    logic       clk, rst_n, ena, wr_req, tx, busy, full, empty, overflow;
    logic [7:0] wr_data;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo_core #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ena_i      (ena),
        .wr_data_i  (wr_data),
        .wr_req_i   (wr_req),
        .tx_o       (tx),
        .busy_o     (busy),
        .full_o     (full),
        .empty_o    (empty),
        .level_o    (level),
        .overflow_o (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // bit 0 = start bit, bits 8:1 = data LSB first, bit 9 = stop
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        wr_data = d;
        wr_req  = 1'b1;
        repeat (3) @(negedge clk);
        wr_req  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Waits (bounded) for the start bit, then samples all 10*CPB cycles of the frame.
    task automatic check_frame(input logic [9:0] exp, input int budget, input string nm);
        bit         found     = 0;
        bit         stable_ok = 1;
        bit         busy_ok   = 1;
        logic [9:0] got       = '0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL %s: no start bit within %0d cycles", nm, budget);
        end else begin
            for (int c = 0; c < 10 * CPB; c++) begin
                if (c > 0) @(negedge clk);
                if (c % CPB == 0) got[c / CPB] = tx;
                else if (tx !== got[c / CPB]) stable_ok = 0;
                if (busy !== 1'b1) busy_ok = 0;
            end
            chk({nm, "_frame"}, 32'(got), 32'(exp));
            chk({nm, "_bit_stable"}, 32'(stable_ok), 1);
            chk({nm, "_busy"}, 32'(busy_ok), 1);
        end
    endtask

    task automatic count_tx_low(input int n, output int lows);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        vecs[0] = '{8'hA5, 10'h34A};
        vecs[1] = '{8'h00, 10'h200};
        vecs[2] = '{8'hFF, 10'h3FE};
        vecs[3] = '{8'h5A, 10'h2B4};
        vecs[4] = '{8'h80, 10'h300};
        vecs[5] = '{8'h01, 10'h202};

        rst_n = 1'b0; ena = 1'b1; wr_req = 1'b0; wr_data = 8'h00;

        // Reset state
        #12;
        chk("rst_tx", 32'(tx), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_tx", 32'(tx), 1);

        // Pin rise to level increment latency
        wr_data = 8'h96;
        wr_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("lat_level_e2", 32'(level), 0);
        @(negedge clk);
        chk("lat_level_e3", 32'(level), 1);
        chk("lat_empty_e3", 32'(empty), 0);
        wr_req = 1'b0;
        check_frame(10'h32C, 3, "lat");
        @(negedge clk);
        chk("lat_idle_busy", 32'(busy), 0);

        // Table of single frames
        for (int v = 0; v < 6; v++) begin
            fork
                push_byte(vecs[v].data);
                check_frame(vecs[v].frame, 20, $sformatf("vec%0d", v));
            join
            @(negedge clk);
            chk($sformatf("vec%0d_busy_after", v), 32'(busy), 0);
            chk($sformatf("vec%0d_tx_after", v), 32'(tx), 1);
        end

        // Back-to-back frames, no idle gap
        fork
            begin push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); end
            begin
                check_frame(10'h202, 20, "b2b0");
                check_frame(10'h204, 1, "b2b1");
                check_frame(10'h206, 1, "b2b2");
            end
        join
        @(negedge clk);
        chk("b2b_busy_after", 32'(busy), 0);

        // Overflow: six pushes during the first frame, fifth fills, sixth drops
        fork
            begin
                push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
                push_byte(8'h44); push_byte(8'h55);
                chk("ovf_full_reached", 32'(full), 1);
                chk("ovf_not_yet", 32'(overflow), 0);
                push_byte(8'h66);
                chk("ovf_set", 32'(overflow), 1);
                chk("ovf_level", 32'(level), 4);
            end
            begin
                check_frame(10'h222, 20, "ovf0");
                check_frame(10'h244, 1, "ovf1");
                check_frame(10'h266, 1, "ovf2");
                check_frame(10'h288, 1, "ovf3");
                check_frame(10'h2AA, 1, "ovf4");
            end
        join
        count_tx_low(30, lows);
        chk("ovf_no_sixth_frame", 32'(lows), 0);
        chk("ovf_empty_after", 32'(empty), 1);
        chk("ovf_sticky", 32'(overflow), 1);

        // Async reset in the middle of data bit 3
        push_byte(8'h00);
        push_byte(8'h00);
        repeat (8) @(negedge clk);
        chk("mid_rst_tx_before", 32'(tx), 0);
        chk("mid_rst_level_before", 32'(level), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_overflow", 32'(overflow), 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_tx_low(12, lows);
        chk("mid_rst_quiet", 32'(lows), 0);

        // ena=0 ignores pushes
        ena = 1'b0;
        push_byte(8'h77);
        count_tx_low(6, lows);
        chk("ena0_quiet", 32'(lows), 0);
        chk("ena0_level", 32'(level), 0);
        chk("ena0_empty", 32'(empty), 1);

        // ena dropping mid-frame: frame completes, queued byte held
        ena = 1'b1;
        fork
            begin push_byte(8'hC3); push_byte(8'h3C); ena = 1'b0; end
            check_frame(10'h386, 20, "ena_f1");
        join
        count_tx_low(20, lows);
        chk("ena_hold_quiet", 32'(lows), 0);
        chk("ena_hold_level", 32'(level), 1);
        ena = 1'b1;
        check_frame(10'h278, 5, "ena_f2");
        @(negedge clk);
        chk("ena_final_busy", 32'(busy), 0);
        chk("ena_final_empty", 32'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
